// File: rtl/i2c_cfg_sequencer_if.sv
// Request/acknowledge bus between the configuration sequencer and an I2C master engine.
interface i2c_cfg_sequencer_if;
  logic        i2c_addr_2byte;
  logic        i2c_write_req;
  logic        i2c_read_req;
  logic        i2c_write_req_ack;
  logic        i2c_read_req_ack;
  logic [7:0]  i2c_slave_dev_addr;
  logic [15:0] i2c_slave_reg_addr;
  logic [7:0]  i2c_write_data;
  logic [7:0]  i2c_read_data;
  logic        i2c_error;

  // Sequencer side: issues requests, receives completions.
  modport master (
    output i2c_addr_2byte,
    output i2c_write_req,
    output i2c_read_req,
    output i2c_slave_dev_addr,
    output i2c_slave_reg_addr,
    output i2c_write_data,
    input  i2c_write_req_ack,
    input  i2c_read_req_ack,
    input  i2c_read_data,
    input  i2c_error
  );

  // I2C engine side: serves requests, returns completions.
  modport slave (
    input  i2c_addr_2byte,
    input  i2c_write_req,
    input  i2c_read_req,
    input  i2c_slave_dev_addr,
    input  i2c_slave_reg_addr,
    input  i2c_write_data,
    output i2c_write_req_ack,
    output i2c_read_req_ack,
    output i2c_read_data,
    output i2c_error
  );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Walks a register-init table and replays each entry as an I2C write (optionally read back),
// with retries on NACK/mismatch and 0xFF device-address entries acting as timed delays.
module i2c_cfg_sequencer #(
  parameter logic        ADDR_2BYTE = 1'b1,
  parameter logic        VERIFY     = 1'b0,
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [15:0] DELAY_UNIT = 16'd50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [9:0]                 lut_size,
  output logic [9:0]                 lut_index,
  input  logic [31:0]                lut_data,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic                       cfg_fail,
  output logic [7:0]                 fail_cnt,
  i2c_cfg_sequencer_if.master        i2c
);

  localparam logic [7:0] MaxRetry = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StDelay, StWrReq, StRdReq, StCheck, StNext, StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  index_q, index_d;
  logic [9:0]  size_q, size_d;
  logic [7:0]  retry_q, retry_d;
  logic [23:0] delay_q, delay_d;
  logic [7:0]  dev_q, dev_d;
  logic [15:0] reg_q, reg_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic        fail_q, fail_d;
  logic [7:0]  fail_cnt_q, fail_cnt_d;
  logic        done_q;
  logic        wr_req_q, rd_req_q;
  logic [23:0] delay_total;

  assign delay_total = 24'(lut_data[7:0]) * 24'(DELAY_UNIT);

  // Next-state and datapath update; every failure path funnels through StCheck so a retry
  // request always starts at least two cycles after the completing ack.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    size_d     = size_q;
    retry_d    = retry_q;
    delay_d    = delay_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    fail_d     = fail_q;
    fail_cnt_d = fail_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          index_d    = 10'd0;
          size_d     = lut_size;
          retry_d    = 8'd0;
          fail_d     = 1'b0;
          fail_cnt_d = 8'd0;
          state_d    = (lut_size == 10'd0) ? StFinish : StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        dev_d  = lut_data[31:24];
        reg_d  = lut_data[23:8];
        data_d = lut_data[7:0];
        if (lut_data[31:24] == 8'hFF) begin
          if (delay_total == 24'd0) begin
            state_d = StNext;
          end else begin
            delay_d = delay_total - 24'd1;
            state_d = StDelay;
          end
        end else begin
          state_d = StWrReq;
        end
      end
      StDelay: begin
        if (delay_q == 24'd0) state_d = StNext;
        else                  delay_d = delay_q - 24'd1;
      end
      StWrReq: begin
        if (i2c.i2c_write_req_ack) begin
          err_d = i2c.i2c_error;
          if (i2c.i2c_error) state_d = StCheck;
          else if (VERIFY)   state_d = StRdReq;
          else               state_d = StNext;
        end
      end
      StRdReq: begin
        if (i2c.i2c_read_req_ack) begin
          err_d     = i2c.i2c_error;
          rd_data_d = i2c.i2c_read_data;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        // err_q alone decides after a NACKed write; readback only matters after a read.
        if (err_q || (rd_data_q != data_q)) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + 8'd1;
            state_d = StWrReq;
          end else begin
            fail_d = 1'b1;
            if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
            state_d = StNext;
          end
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        retry_d = 8'd0;
        if (index_q == size_q - 10'd1) begin
          state_d = StFinish;
        end else begin
          index_d = index_q + 10'd1;
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, datapath and registered outputs; reset drops any request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      index_q    <= 10'd0;
      size_q     <= 10'd0;
      retry_q    <= 8'd0;
      delay_q    <= 24'd0;
      dev_q      <= 8'd0;
      reg_q      <= 16'd0;
      data_q     <= 8'd0;
      rd_data_q  <= 8'd0;
      err_q      <= 1'b0;
      fail_q     <= 1'b0;
      fail_cnt_q <= 8'd0;
      done_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      size_q     <= size_d;
      retry_q    <= retry_d;
      delay_q    <= delay_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
      done_q     <= (state_q == StFinish);
      wr_req_q   <= (state_d == StWrReq);
      rd_req_q   <= (state_d == StRdReq);
    end
  end

  assign lut_index              = index_q;
  assign cfg_busy               = (state_q != StIdle);
  assign cfg_done               = done_q;
  assign cfg_fail               = fail_q;
  assign fail_cnt               = fail_cnt_q;
  assign i2c.i2c_addr_2byte     = ADDR_2BYTE;
  assign i2c.i2c_write_req      = wr_req_q;
  assign i2c.i2c_read_req       = rd_req_q;
  assign i2c.i2c_slave_dev_addr = dev_q;
  assign i2c.i2c_slave_reg_addr = reg_q;
  assign i2c.i2c_write_data     = data_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: a plain-write instance and a verify instance share one table ROM,
// one randomized I2C engine model and one transaction-level reference model.
module tb_i2c_cfg_sequencer;

  localparam int MaxRetry  = 3;
  localparam int DelayUnit = 10;
  localparam int Limit     = 4000;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic        clr;
  logic        sel;
  logic [9:0]  lut_size;

  logic [9:0]  idx_a, idx_v;
  logic [31:0] lut_data_a, lut_data_v;
  logic        busy_a, busy_v, done_a, done_v, fail_a, fail_v;
  logic [7:0]  fcnt_a, fcnt_v;

  logic [31:0] rom [16];
  int          wr_fail_n [16];
  int          rd_bad_n [16];

  i2c_cfg_sequencer_if bus_a ();
  i2c_cfg_sequencer_if bus_v ();

  i2c_cfg_sequencer #(
    .ADDR_2BYTE(1'b1), .VERIFY(1'b0), .MAX_RETRY(MaxRetry), .DELAY_UNIT(16'(DelayUnit))
  ) dut_a (
    .clk(clk), .rst(rst), .cfg_start(cfg_start & ~sel), .lut_size(lut_size),
    .lut_index(idx_a), .lut_data(lut_data_a), .cfg_busy(busy_a), .cfg_done(done_a),
    .cfg_fail(fail_a), .fail_cnt(fcnt_a), .i2c(bus_a)
  );

  i2c_cfg_sequencer #(
    .ADDR_2BYTE(1'b1), .VERIFY(1'b1), .MAX_RETRY(MaxRetry), .DELAY_UNIT(16'(DelayUnit))
  ) dut_v (
    .clk(clk), .rst(rst), .cfg_start(cfg_start & sel), .lut_size(lut_size),
    .lut_index(idx_v), .lut_data(lut_data_v), .cfg_busy(busy_v), .cfg_done(done_v),
    .cfg_fail(fail_v), .fail_cnt(fcnt_v), .i2c(bus_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table ROM with one cycle of read latency per instance.
  always @(posedge clk) begin
    lut_data_a <= rom[idx_a[3:0]];
    lut_data_v <= rom[idx_v[3:0]];
  end

  // Selected-instance view.
  logic        s_wreq, s_rreq, s_busy, s_done, s_fail;
  logic [9:0]  s_index;
  logic [7:0]  s_dev, s_wdata, s_fcnt;
  logic [15:0] s_reg;
  logic        s_wack, s_rack, s_err;
  logic [7:0]  s_rdata;
  logic [3:0]  si;

  assign s_wreq  = sel ? bus_v.i2c_write_req : bus_a.i2c_write_req;
  assign s_rreq  = sel ? bus_v.i2c_read_req : bus_a.i2c_read_req;
  assign s_dev   = sel ? bus_v.i2c_slave_dev_addr : bus_a.i2c_slave_dev_addr;
  assign s_reg   = sel ? bus_v.i2c_slave_reg_addr : bus_a.i2c_slave_reg_addr;
  assign s_wdata = sel ? bus_v.i2c_write_data : bus_a.i2c_write_data;
  assign s_index = sel ? idx_v : idx_a;
  assign s_busy  = sel ? busy_v : busy_a;
  assign s_done  = sel ? done_v : done_a;
  assign s_fail  = sel ? fail_v : fail_a;
  assign s_fcnt  = sel ? fcnt_v : fcnt_a;
  assign si      = s_index[3:0];

  assign bus_a.i2c_write_req_ack = s_wack & ~sel;
  assign bus_a.i2c_read_req_ack  = s_rack & ~sel;
  assign bus_a.i2c_read_data     = s_rdata;
  assign bus_a.i2c_error         = s_err;
  assign bus_v.i2c_write_req_ack = s_wack & sel;
  assign bus_v.i2c_read_req_ack  = s_rack & sel;
  assign bus_v.i2c_read_data     = s_rdata;
  assign bus_v.i2c_error         = s_err;

  // I2C engine model: random latency, per-entry NACK/bad-readback budgets, and stray acks of
  // the other kind while a request is pending.
  int   lat;
  logic pend_rd;
  int   att_wr [16];
  int   att_rd [16];
  always @(posedge clk) begin
    s_wack <= 1'b0;
    s_rack <= 1'b0;
    s_err  <= 1'b0;
    if (rst || clr) begin
      lat <= 0;
      pend_rd <= 1'b0;
      s_rdata <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        att_wr[i] <= 0;
        att_rd[i] <= 0;
      end
    end else if (lat > 1) begin
      lat <= lat - 1;
      if ($urandom_range(0, 3) == 0) begin
        if (pend_rd) s_wack <= 1'b1;
        else         s_rack <= 1'b1;
      end
    end else if (lat == 1) begin
      lat <= 0;
      if (pend_rd) begin
        s_rack  <= 1'b1;
        s_rdata <= (att_rd[si] < rd_bad_n[si]) ? (s_wdata ^ 8'h55) : s_wdata;
        att_rd[si] <= att_rd[si] + 1;
        if ($urandom_range(0, 3) == 0) s_wack <= 1'b1;
      end else begin
        s_wack <= 1'b1;
        s_err  <= (att_wr[si] < wr_fail_n[si]);
        att_wr[si] <= att_wr[si] + 1;
        if ($urandom_range(0, 3) == 0) s_rack <= 1'b1;
      end
    end else if (s_wreq && !s_wack) begin
      lat <= $urandom_range(1, 4);
      pend_rd <= 1'b0;
    end else if (s_rreq && !s_rack) begin
      lat <= $urandom_range(1, 4);
      pend_rd <= 1'b1;
    end
  end

  // Monitor: completed transactions, done pulses, index-0 dwell, request hold and retry gap.
  logic [32:0] obs_tx [128];
  int          obs_n;
  int          done_cnt;
  int          idx0_cnt;
  int          since_ack;
  int          hold_viol = 0;
  int          gap_viol  = 0;
  logic        need_w, need_r, prev_wreq;
  logic [31:0] snap;
  always @(posedge clk) begin
    if (rst || clr) begin
      obs_n     <= 0;
      done_cnt  <= 0;
      idx0_cnt  <= 0;
      since_ack <= 100;
      need_w    <= 1'b0;
      need_r    <= 1'b0;
      prev_wreq <= 1'b0;
      snap      <= 32'd0;
    end else begin
      if (s_wreq && s_wack) begin
        if (obs_n < 128) obs_tx[obs_n] <= {1'b0, s_dev, s_reg, s_wdata};
        obs_n <= obs_n + 1;
      end else if (s_rreq && s_rack) begin
        if (obs_n < 128) obs_tx[obs_n] <= {1'b1, s_dev, s_reg, s_wdata};
        obs_n <= obs_n + 1;
      end
      if (s_done) done_cnt <= done_cnt + 1;
      if (s_busy && s_index == 10'd0) idx0_cnt <= idx0_cnt + 1;
      if ((s_wreq && s_wack) || (s_rreq && s_rack)) since_ack <= 0;
      else if (since_ack < 100) since_ack <= since_ack + 1;
      if (s_wreq && !prev_wreq && since_ack == 0) gap_viol <= gap_viol + 1;
      prev_wreq <= s_wreq;
      if ((need_w && !s_wreq) || (need_r && !s_rreq) ||
          ((need_w || need_r) && {s_dev, s_reg, s_wdata} != snap))
        hold_viol <= hold_viol + 1;
      need_w <= s_wreq && !s_wack;
      need_r <= s_rreq && !s_rack;
      snap   <= {s_dev, s_reg, s_wdata};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected transaction list and failure count from the table and the engine's fault budgets.
  logic [32:0] exp_tx [128];
  task automatic model(input bit ver, input int size, output int n, output int fails);
    logic [31:0] e;
    int aw, ar;
    bit ok, bad;
    n = 0;
    fails = 0;
    for (int i = 0; i < size; i++) begin
      e = rom[i];
      if (e[31:24] != 8'hFF) begin
        aw = 0;
        ar = 0;
        ok = 1'b0;
        for (int a = 0; a <= MaxRetry; a++) begin
          if (!ok) begin
            exp_tx[n] = {1'b0, e};
            n++;
            bad = (aw < wr_fail_n[i]);
            aw++;
            if (!bad && ver) begin
              exp_tx[n] = {1'b1, e};
              n++;
              bad = (ar < rd_bad_n[i]);
              ar++;
            end
            ok = !bad;
          end
        end
        if (!ok) fails++;
      end
    end
  endtask

  task automatic clear_policy();
    for (int i = 0; i < 16; i++) begin
      wr_fail_n[i] = 0;
      rd_bad_n[i]  = 0;
    end
  endtask

  task automatic run_pass(input bit ver, input int size, input string tag);
    int cyc, n_exp, f_exp;
    @(negedge clk);
    sel = ver;
    lut_size = 10'(size);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cyc = 1;
    while (!s_done && cyc < Limit) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(s_done), 64'd1);
    repeat (3) @(negedge clk);
    model(ver, size, n_exp, f_exp);
    if (size == 0) check({tag, "_done_latency"}, 64'(cyc), 64'd2);
    check({tag, "_ntx"}, 64'(obs_n), 64'(n_exp));
    for (int k = 0; k < n_exp && k < obs_n && k < 128; k++)
      check($sformatf("%s_tx%0d", tag, k), 64'(obs_tx[k]), 64'(exp_tx[k]));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_cfg_fail"}, 64'(s_fail), 64'(f_exp != 0));
    check({tag, "_fail_cnt"}, 64'(s_fcnt), 64'((f_exp > 255) ? 255 : f_exp));
    check({tag, "_busy_end"}, 64'(s_busy), 64'd0);
    if (size >= 2 && rom[0][31:24] == 8'hFF)
      check({tag, "_delay0"}, 64'(idx0_cnt), 64'(3 + int'(rom[0][7:0]) * DelayUnit));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad;
    logic [7:0] dev;
    rst = 1'b1;
    cfg_start = 1'b0;
    clr = 1'b0;
    sel = 1'b0;
    lut_size = 10'd0;
    clear_policy();
    for (int i = 0; i < 16; i++) rom[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_outputs_a", 64'({idx_a, bus_a.i2c_write_req, bus_a.i2c_read_req,
          bus_a.i2c_slave_dev_addr, bus_a.i2c_slave_reg_addr, bus_a.i2c_write_data,
          busy_a, done_a, fail_a, fcnt_a}), 64'd0);
    check("rst_outputs_v", 64'({idx_v, bus_v.i2c_write_req, bus_v.i2c_read_req,
          bus_v.i2c_slave_dev_addr, bus_v.i2c_slave_reg_addr, bus_v.i2c_write_data,
          busy_v, done_v, fail_v, fcnt_v}), 64'd0);
    check("addr_2byte", 64'({bus_a.i2c_addr_2byte, bus_v.i2c_addr_2byte}), 64'd3);
    rst = 1'b0;

    // Three plain writes.
    rom[0] = {8'h78, 16'h3008, 8'h82};
    rom[1] = {8'h78, 16'h3103, 8'h03};
    rom[2] = {8'h78, 16'h3017, 8'hFF};
    run_pass(1'b0, 3, "basic");

    // Delay entry of 2 ticks ahead of a write.
    rom[0] = {8'hFF, 16'h0000, 8'h02};
    run_pass(1'b0, 2, "delay");

    // Entry that NACKs every attempt; following entry still written.
    rom[0] = {8'h78, 16'h3008, 8'h82};
    rom[1] = {8'hAA, 16'h1234, 8'h11};
    rom[2] = {8'h78, 16'h3017, 8'h5C};
    wr_fail_n[1] = 99;
    run_pass(1'b0, 3, "nack");
    clear_policy();

    // Verify: first readback wrong, second right.
    rom[0] = {8'h78, 16'h3008, 8'h55};
    rd_bad_n[0] = 1;
    run_pass(1'b1, 1, "verify");
    clear_policy();

    run_pass(1'b0, 0, "empty");

    // Reset while a write request is outstanding, with a start pulse while busy.
    rom[0] = {8'h78, 16'h4000, 8'h12};
    @(negedge clk);
    sel = 1'b0;
    lut_size = 10'd1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cyc = 0;
    while (!s_wreq && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_req_seen", 64'(s_wreq), 64'd1);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_req_drop", 64'({s_wreq, s_busy, s_index}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (s_busy || s_done || s_wreq || s_rreq) bad++;
    end
    check("rst_no_restart", 64'(bad), 64'd0);

    // Randomized tables on both instances.
    for (int t = 0; t < 12; t++) begin
      clear_policy();
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          rom[i] = {8'hFF, 16'($urandom), 8'($urandom_range(0, 3))};
        end else begin
          dev = 8'($urandom_range(0, 254));
          rom[i] = {dev, 16'($urandom), 8'($urandom)};
        end
        if ($urandom_range(0, 2) == 0) wr_fail_n[i] = $urandom_range(1, 5);
        if ($urandom_range(0, 2) == 0) rd_bad_n[i] = $urandom_range(1, 5);
      end
      run_pass(1'(t % 2), $urandom_range(1, 8), $sformatf("rnd%0d", t));
    end

    check("req_hold", 64'(hold_viol), 64'd0);
    check("retry_gap", 64'(gap_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
